// File: rtl/cc_pkg.sv
// rtl/cc_pkg.sv - shared rate/state types and puncture constants for the K=7 encoder burst sequencer
package cc_pkg;

  localparam int CC_RATE_W   = 2;
  localparam int CC_TAIL_LEN = 6;

  typedef enum logic [CC_RATE_W-1:0] {
    CC_R12 = 2'd0,
    CC_R23 = 2'd1,
    CC_R34 = 2'd2,
    CC_R56 = 2'd3
  } cc_rate_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_TAIL
  } cc_state_e;

  localparam logic [2:0] CC_PER_M1_12 = 3'd0;
  localparam logic [2:0] CC_PER_M1_23 = 3'd1;
  localparam logic [2:0] CC_PER_M1_34 = 3'd2;
  localparam logic [2:0] CC_PER_M1_56 = 3'd4;

  // {keep Y, keep X} per puncture step, step 0 in the lowest pair
  localparam logic [9:0] CC_KEEP_12 = 10'b00_00_00_00_11;
  localparam logic [9:0] CC_KEEP_23 = 10'b00_00_00_10_11;
  localparam logic [9:0] CC_KEEP_34 = 10'b00_00_01_10_11;
  localparam logic [9:0] CC_KEEP_56 = 10'b01_10_01_10_11;

endpackage

// File: rtl/cc_punct_lut.sv
// rtl/cc_punct_lut.sv - (rate, step) to puncture keep-mask and period-1; shared with the depuncturer
module cc_punct_lut
  import cc_pkg::*;
(
  input  cc_rate_e   rate,
  input  logic [2:0] step,
  output logic [1:0] keep,
  output logic [2:0] per_m1
);

  logic [9:0] tbl;
  logic [3:0] idx;

  always_comb begin
    tbl    = CC_KEEP_12;
    per_m1 = CC_PER_M1_12;
    case (rate)
      CC_R12: begin tbl = CC_KEEP_12; per_m1 = CC_PER_M1_12; end
      CC_R23: begin tbl = CC_KEEP_23; per_m1 = CC_PER_M1_23; end
      CC_R34: begin tbl = CC_KEEP_34; per_m1 = CC_PER_M1_34; end
      CC_R56: begin tbl = CC_KEEP_56; per_m1 = CC_PER_M1_56; end
      default: begin tbl = CC_KEEP_12; per_m1 = CC_PER_M1_12; end
    endcase
    idx  = {step, 1'b0};
    keep = tbl[idx +: 2];
  end

endmodule

// File: rtl/cc_ctrl.sv
// rtl/cc_ctrl.sv - block burst sequencer feeding the 1/2-rate K=7 encoder with puncture masks
// CC_TAIL_EN: when defined, 6 zero tail bits flush the encoder after each block.
module cc_ctrl
  import cc_pkg::*;
#(
  parameter int blk_max = 288,
  parameter int len_w   = $clog2(blk_max+1),
`ifdef CC_TAIL_EN
  parameter int cnt_w   = $clog2(2*(blk_max+CC_TAIL_LEN)+1)
`else
  parameter int cnt_w   = $clog2(2*blk_max+1)
`endif
)(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [len_w-1:0]     blk_len,
  input  logic [CC_RATE_W-1:0] cc_rate,
  input  logic                 in_bit,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 enc_bit,
  output logic                 enc_valid,
  output logic [1:0]           punct_keep,
  output logic                 enc_last,
  output logic [cnt_w-1:0]     kept_cnt,
  output logic                 busy
);

  cc_state_e        state;
  cc_rate_e         rate_q;
  logic [len_w-1:0] len_q;
  logic [len_w-1:0] bit_cnt;
  logic [2:0]       step;
  logic [1:0]       keep_now;
  logic [2:0]       per_m1;
  logic [len_w-1:0] len_clamp;
  logic [1:0]       pop;
  logic             emit;

`ifdef CC_TAIL_EN
  localparam logic [2:0] TAIL_LAST = 3'(CC_TAIL_LEN-1);
  logic [2:0] tail_cnt;
`endif

  cc_punct_lut u_lut (
    .rate   (rate_q),
    .step   (step),
    .keep   (keep_now),
    .per_m1 (per_m1)
  );

  always_comb begin
    len_clamp = (blk_len > len_w'(blk_max)) ? len_w'(blk_max) : blk_len;
    pop       = {1'b0, keep_now[1]} + {1'b0, keep_now[0]};
    emit      = (state == ST_DATA && in_valid && in_ready) || (state == ST_TAIL);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      rate_q     <= CC_R12;
      len_q      <= '0;
      bit_cnt    <= '0;
      step       <= '0;
      in_ready   <= 1'b0;
      enc_bit    <= 1'b0;
      enc_valid  <= 1'b0;
      punct_keep <= '0;
      enc_last   <= 1'b0;
      kept_cnt   <= '0;
      busy       <= 1'b0;
`ifdef CC_TAIL_EN
      tail_cnt   <= '0;
`endif
    end else begin
      enc_valid  <= 1'b0;
      enc_bit    <= 1'b0;
      punct_keep <= '0;
      enc_last   <= 1'b0;

      // every emitted step, data or tail, advances the puncture pattern
      if (emit) begin
        enc_valid  <= 1'b1;
        enc_bit    <= (state == ST_DATA) && in_bit;
        punct_keep <= keep_now;
        kept_cnt   <= kept_cnt + cnt_w'(pop);
        step       <= (step == per_m1) ? 3'd0 : step + 3'd1;
      end

      case (state)
        ST_IDLE: begin
          busy <= 1'b0;
          if (start) begin
            len_q    <= len_clamp;
            rate_q   <= cc_rate_e'(cc_rate);
            bit_cnt  <= '0;
            step     <= '0;
            kept_cnt <= '0;
`ifdef CC_TAIL_EN
            tail_cnt <= '0;
`endif
            if (len_clamp != '0) begin
              state    <= ST_DATA;
              busy     <= 1'b1;
              in_ready <= 1'b1;
            end
`ifdef CC_TAIL_EN
            else begin
              state <= ST_TAIL;
              busy  <= 1'b1;
            end
`endif
          end
        end
        ST_DATA: begin
          if (in_valid && in_ready) begin
            bit_cnt <= bit_cnt + len_w'(1);
            if (bit_cnt + len_w'(1) == len_q) begin
              in_ready <= 1'b0;
`ifdef CC_TAIL_EN
              state    <= ST_TAIL;
`else
              state    <= ST_IDLE;
              enc_last <= 1'b1;
`endif
            end
          end
        end
`ifdef CC_TAIL_EN
        ST_TAIL: begin
          tail_cnt <= tail_cnt + 3'd1;
          if (tail_cnt == TAIL_LAST) begin
            enc_last <= 1'b1;
            state    <= ST_IDLE;
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cc_ctrl.sv
// tb/tb_cc_ctrl.sv - scoreboard bench for cc_ctrl with a step-list reference model
module tb_cc_ctrl;

  localparam int BLK_MAX = 288;
`ifdef CC_TAIL_EN
  localparam int TAIL = 6;
`else
  localparam int TAIL = 0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [8:0] blk_len = '0;
  logic [1:0] cc_rate = '0;
  logic       in_bit = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready, enc_bit, enc_valid, enc_last, busy;
  logic [1:0] punct_keep;
  logic [9:0] kept_cnt;

  cc_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .blk_len    (blk_len),
    .cc_rate    (cc_rate),
    .in_bit     (in_bit),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .enc_bit    (enc_bit),
    .enc_valid  (enc_valid),
    .punct_keep (punct_keep),
    .enc_last   (enc_last),
    .kept_cnt   (kept_cnt),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int b;
    int keep;
    int last;
    int kept;
  } step_t;

  step_t sb[$];
  step_t mon_e;
  int    checks = 0;
  int    failures = 0;
  int    steps_seen = 0;
  logic  blk_bits [BLK_MAX];
  int    period [4] = '{1, 2, 3, 5};
  int    keep_tab [4][5] = '{'{3, 0, 0, 0, 0}, '{3, 2, 0, 0, 0},
                             '{3, 2, 1, 0, 0}, '{3, 2, 1, 2, 1}};

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (enc_valid) begin
        steps_seen++;
        if (sb.size() == 0) begin
          chk("unexpected_step", 1, 0);
        end else begin
          mon_e = sb.pop_front();
          chk("enc_bit", int'(enc_bit), mon_e.b);
          chk("punct_keep", int'(punct_keep), mon_e.keep);
          chk("enc_last", int'(enc_last), mon_e.last);
          chk("kept_cnt", int'(kept_cnt), mon_e.kept);
        end
      end else begin
        chk("idle_last", int'(enc_last), 0);
        chk("idle_keep", int'(punct_keep), 0);
      end
    end
  end

  task automatic push_block(input int rate, input int len);
    int n = (len > BLK_MAX) ? BLK_MAX : len;
    int total = n + TAIL;
    int kept = 0;
    for (int i = 0; i < total; i++) begin
      step_t s;
      s.b    = (i < n) ? int'(blk_bits[i]) : 0;
      s.keep = keep_tab[rate][i % period[rate]];
      kept  += (s.keep & 1) + (s.keep >> 1);
      s.kept = kept;
      s.last = (i == total - 1) ? 1 : 0;
      sb.push_back(s);
    end
  endtask

  task automatic wait_idle();
    int w = 0;
    while (busy && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    if (busy) chk("idle_timeout", int'(busy), 0);
  endtask

  task automatic run_block(input int rate, input int len, input int vmode);
    int n = (len > BLK_MAX) ? BLK_MAX : len;
    int idx = 0;
    int cyc = 0;
    bit acc;
    wait_idle();
    push_block(rate, len);
    @(posedge clk); #1;
    start = 1'b1; blk_len = len[8:0]; cc_rate = rate[1:0];
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", int'(busy), (n > 0 || TAIL > 0) ? 1 : 0);
    chk("in_ready_after_start", int'(in_ready), (n > 0) ? 1 : 0);
    while (idx < n && cyc < 4000) begin
      in_bit = blk_bits[idx];
      case (vmode)
        0:       in_valid = 1'b1;
        1:       in_valid = (cyc % 2 == 0);
        default: in_valid = 1'($urandom_range(0, 1));
      endcase
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      cyc++;
      if (acc) idx++;
    end
    in_valid = 1'b0;
    if (idx < n) chk("feed_timeout", idx, n);
    else if (n > 0) chk("in_ready_after_last", int'(in_ready), 0);
    for (int k = 2; k <= 8; k++) begin
      @(posedge clk); #1;
      chk("tail_valid", int'(enc_valid), (k <= TAIL + 1) ? 1 : 0);
      chk("busy_end", int'(busy), (k < TAIL + 2) ? 1 : 0);
    end
    chk("sb_empty", sb.size(), 0);
  endtask

  task automatic abort_test();
    int target = (TAIL > 0) ? 8 + 3 : 3;
    int w = 0;
    wait_idle();
    for (int i = 0; i < 8; i++) blk_bits[i] = 1'b1;
    push_block(1, 8);
    steps_seen = 0;
    @(posedge clk); #1;
    start = 1'b1; blk_len = 9'd8; cc_rate = 2'd1;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b1; in_bit = 1'b1;
    @(posedge clk); #1;
    start = 1'b1; blk_len = 9'd3; cc_rate = 2'd3;
    @(posedge clk); #1;
    start = 1'b0;
    while (steps_seen < target && w < 100) begin
      @(negedge clk); #1;
      w++;
    end
    chk("abort_reach", steps_seen, target);
    reset = 1'b1;
    in_valid = 1'b0;
    #1;
    sb.delete();
    chk("rst_enc_valid", int'(enc_valid), 0);
    chk("rst_enc_last", int'(enc_last), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_kept_cnt", int'(kept_cnt), 0);
    chk("rst_keep", int'(punct_keep), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("post_rst_valid", int'(enc_valid), 0);
      chk("post_rst_last", int'(enc_last), 0);
      chk("post_rst_busy", int'(busy), 0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] pat;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_enc_valid", int'(enc_valid), 0);
    chk("reset_enc_bit", int'(enc_bit), 0);
    chk("reset_enc_last", int'(enc_last), 0);
    chk("reset_keep", int'(punct_keep), 0);
    chk("reset_kept_cnt", int'(kept_cnt), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_in_ready", int'(in_ready), 0);
    reset = 1'b0;

    pat = 10'b1011001110;
    for (int i = 0; i < 10; i++) blk_bits[i] = pat[9-i];
    run_block(0, 10, 0);
    for (int i = 0; i < BLK_MAX; i++) blk_bits[i] = 1'($urandom_range(0, 1));
    run_block(2, 12, 1);
    run_block(3, 4, 0);
    run_block(1, 0, 0);
    abort_test();
    for (int i = 0; i < BLK_MAX; i++) blk_bits[i] = 1'($urandom_range(0, 1));
    run_block(0, 5, 0);
    run_block(3, 300, 2);

    for (int t = 0; t < 25; t++) begin
      for (int i = 0; i < BLK_MAX; i++) blk_bits[i] = 1'($urandom_range(0, 1));
      run_block(int'($urandom_range(0, 3)), int'($urandom_range(0, 24)), int'($urandom_range(0, 2)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
